// File: rtl/draw_sequencer.sv
// Raster draw sequencer: walks a full-screen or sprite ROM address range and emits
// VGA x/y/plot one cycle behind the address to match the ROMs' registered read latency.
module draw_sequencer #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned SPRITE_W = 40,
    parameter int unsigned SPRITE_H = 40
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  xOrigin,
    input  logic [6:0]  yOrigin,
    output logic [14:0] address,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [14:0] ScrLast = 15'(SCREEN_W * SCREEN_H - 1);
    localparam logic [14:0] SprLast = 15'(SPRITE_W * SPRITE_H - 1);
    localparam logic [7:0]  ScrColLast = 8'(SCREEN_W - 1);
    localparam logic [7:0]  SprColLast = 8'(SPRITE_W - 1);
    localparam logic [7:0]  ScrW8 = 8'(SCREEN_W);
    localparam logic [7:0]  ScrH8 = 8'(SCREEN_H);

    typedef enum logic [1:0] {StIdle, StDraw, StFlush, StDone} state_t;

    state_t      state;
    logic        mode_q;
    logic [7:0]  xo_q;
    logic [6:0]  yo_q;
    logic [14:0] count;
    logic [7:0]  col;
    logic [6:0]  row;

    logic [14:0] last_idx;
    logic [7:0]  col_last;
    logic [7:0]  x_sum;
    logic [7:0]  y_sum;
    logic        clipped;

    always_comb begin
        last_idx = mode_q ? SprLast : ScrLast;
        col_last = mode_q ? SprColLast : ScrColLast;
        x_sum    = xo_q + col;
        y_sum    = {1'b0, yo_q} + {1'b0, row};
        clipped  = (x_sum >= ScrW8) || (y_sum >= ScrH8);
    end

    // count doubles as the ROM address; it holds N-1 through FLUSH
    assign address = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= StIdle;
            mode_q <= 1'b0;
            xo_q   <= '0;
            yo_q   <= '0;
            count  <= '0;
            col    <= '0;
            row    <= '0;
            x      <= '0;
            y      <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // Pixel for the address driven during the cycle just ending
            x    <= x_sum;
            y    <= y_sum[6:0];
            plot <= (state == StDraw) && !clipped;
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        mode_q <= mode;
                        xo_q   <= mode ? xOrigin : 8'd0;
                        yo_q   <= mode ? yOrigin : 7'd0;
                        count  <= '0;
                        col    <= '0;
                        row    <= '0;
                        busy   <= 1'b1;
                        state  <= StDraw;
                    end
                end
                StDraw: begin
                    if (count == last_idx) begin
                        state <= StFlush;
                    end else begin
                        count <= count + 15'd1;
                        if (col == col_last) begin
                            col <= '0;
                            row <= row + 7'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                StFlush: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: screen, sprite, clipped, ignored restart,
// mid-draw reset and back-to-back draws.
module tb_draw_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  xOrigin = '0;
    logic [6:0]  yOrigin = '0;
    logic [14:0] address;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        plot;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    int plots, done_cnt, busy_cyc, done_edge, first_edge, last_edge;
    int pix_err, addr_err, first_addr;
    int fx, fy, lx, ly, minx, maxx, miny, maxy;
    bit timeout;
    int bad;

    draw_sequencer dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .mode    (mode),
        .xOrigin (xOrigin),
        .yOrigin (yOrigin),
        .address (address),
        .x       (x),
        .y       (y),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is just after a clock edge; the next edge is the start edge (edge 1).
    // Sample k is taken #1 after edge k+1.
    task automatic run_draw(input bit m, input int xo, input int yo, input bit hold,
                            input int restart_at);
        int w, n, xl, yl, prev, ex, ey;
        w  = m ? 40 : 160;
        n  = m ? 1600 : 19200;
        xl = m ? xo : 0;
        yl = m ? yo : 0;
        plots = 0; done_cnt = 0; busy_cyc = 0; done_edge = -1;
        first_edge = -1; last_edge = -1; pix_err = 0; addr_err = 0; first_addr = -1;
        fx = -1; fy = -1; lx = -1; ly = -1;
        minx = 9999; maxx = -1; miny = 9999; maxy = -1;
        timeout = 1'b1;
        prev = -1;
        mode = m; xOrigin = 8'(xo); yOrigin = 7'(yo); start = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            // Inputs scrambled after the start edge must not affect this draw
            start = 1'b0; mode = ~m; xOrigin = 8'd200; yOrigin = 7'd99;
        end
        for (int k = 0; k < n + 20; k++) begin
            if (k == 0) first_addr = int'(address);
            if (busy) begin
                busy_cyc++;
                if (int'(address) != ((k < n) ? k : n - 1)) addr_err++;
            end
            if (plot) begin
                plots++;
                ex = (xl + prev % w) % 256;
                ey = ((yl + prev / w) % 256) % 128;
                if (prev < 0 || int'(x) != ex || int'(y) != ey) pix_err++;
                if (plots == 1) begin
                    fx = int'(x); fy = int'(y); first_edge = k + 1;
                end
                lx = int'(x); ly = int'(y); last_edge = k + 1;
                if (int'(x) < minx) minx = int'(x);
                if (int'(x) > maxx) maxx = int'(x);
                if (int'(y) < miny) miny = int'(y);
                if (int'(y) > maxy) maxy = int'(y);
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_edge = k + 1;
            end
            if (restart_at >= 0 && k == restart_at) start = 1'b1;
            if (restart_at >= 0 && k == restart_at + 1) start = 1'b0;
            if (done_cnt > 0 && (hold || k + 1 >= done_edge + 2)) begin
                timeout = 1'b0;
                break;
            end
            prev = int'(address);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge
        #2 resetn = 1'b0;
        #1;
        check("rst_address", address, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // Full screen
        run_draw(1'b0, 33, 21, 1'b0, -1);
        check("scr_timeout", timeout, 0);
        check("scr_plots", plots, 19200);
        check("scr_first_addr", first_addr, 0);
        check("scr_first_edge", first_edge, 2);
        check("scr_first_x", fx, 0);
        check("scr_first_y", fy, 0);
        check("scr_last_x", lx, 159);
        check("scr_last_y", ly, 119);
        check("scr_contig", last_edge - first_edge + 1, 19200);
        check("scr_pix_err", pix_err, 0);
        check("scr_addr_err", addr_err, 0);
        check("scr_busy_cyc", busy_cyc, 19201);
        check("scr_done_cnt", done_cnt, 1);
        check("scr_done_edge", done_edge, 19202);

        // Sprite at (60,40)
        run_draw(1'b1, 60, 40, 1'b0, -1);
        check("spr_timeout", timeout, 0);
        check("spr_plots", plots, 1600);
        check("spr_minx", minx, 60);
        check("spr_maxx", maxx, 99);
        check("spr_miny", miny, 40);
        check("spr_maxy", maxy, 79);
        check("spr_pix_err", pix_err, 0);
        check("spr_addr_err", addr_err, 0);
        check("spr_contig", last_edge - first_edge + 1, 1600);
        check("spr_done_edge", done_edge, 1602);
        check("spr_done_cnt", done_cnt, 1);

        // Sprite clipped at the right/bottom edge
        run_draw(1'b1, 140, 100, 1'b0, -1);
        check("clip_timeout", timeout, 0);
        check("clip_plots", plots, 400);
        check("clip_maxx", maxx, 159);
        check("clip_maxy", maxy, 119);
        check("clip_minx", minx, 140);
        check("clip_pix_err", pix_err, 0);
        check("clip_busy_cyc", busy_cyc, 1601);
        check("clip_done_cnt", done_cnt, 1);
        check("clip_done_edge", done_edge, 1602);

        // start re-pulsed during DRAW is ignored
        run_draw(1'b1, 5, 7, 1'b0, 500);
        check("rstrt_timeout", timeout, 0);
        check("rstrt_plots", plots, 1600);
        check("rstrt_done_cnt", done_cnt, 1);
        check("rstrt_done_edge", done_edge, 1602);
        check("rstrt_addr_err", addr_err, 0);
        check("rstrt_idle_busy", busy, 0);

        // Reset mid-draw
        mode = 1'b1; xOrigin = 8'd10; yOrigin = 7'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bad = 1;
        for (int i = 0; i < 2000; i++) begin
            if (address == 15'd800) begin
                bad = 0;
                break;
            end
            @(posedge clk); #1;
        end
        check("mid_reach_800", bad, 0);
        check("mid_busy_before", busy, 1);
        #4 resetn = 1'b0;
        #1;
        check("mid_plot_drop", plot, 0);
        check("mid_busy_drop", busy, 0);
        check("mid_addr_clear", address, 0);
        @(posedge clk); #4;
        resetn = 1'b1;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (plot || done || busy) bad++;
        end
        check("mid_quiet", bad, 0);
        run_draw(1'b1, 10, 10, 1'b0, -1);
        check("mid_timeout", timeout, 0);
        check("mid_plots", plots, 1600);
        check("mid_first_addr", first_addr, 0);
        check("mid_first_x", fx, 10);
        check("mid_first_y", fy, 10);
        check("mid_addr_err", addr_err, 0);
        check("mid_done_cnt", done_cnt, 1);

        // start held high: back-to-back draws
        run_draw(1'b1, 0, 0, 1'b1, -1);
        check("b2b1_timeout", timeout, 0);
        check("b2b1_plots", plots, 1600);
        check("b2b1_done_edge", done_edge, 1602);
        @(posedge clk); #1;
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_done", done, 0);
        run_draw(1'b1, 0, 0, 1'b1, -1);
        start = 1'b0;
        check("b2b2_timeout", timeout, 0);
        check("b2b2_busy_rise", busy_cyc, 1601);
        check("b2b2_plots", plots, 1600);
        check("b2b2_first_edge", first_edge, 2);
        check("b2b2_addr_err", addr_err, 0);
        check("b2b2_pix_err", pix_err, 0);
        check("b2b2_maxx", maxx, 39);
        check("b2b2_maxy", maxy, 39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter SCREEN_W, 160, full-screen width in pixels.
REQ-002 Parameter SCREEN_H, 120, full-screen height in pixels.
REQ-003 Parameter SPRITE_W, 40, sprite width in pixels.
REQ-004 Parameter SPRITE_H, 40, sprite height in pixels.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  draw request, sampled only in IDLE.
- mode  in  1  0 = full screen (SCREEN_W x SCREEN_H), 1 = sprite (SPRITE_W x SPRITE_H).
- xOrigin  in  8  sprite top-left x; ignored when mode=0.
- yOrigin  in  7  sprite top-left y; ignored when mode=0.
- address  out  15  ROM read address driven to the screen/sprite ROMs (sprite uses bits [10:0], upper bits 0).
- x  out  8  VGA pixel x, aligned with plot.
- y  out  7  VGA pixel y, aligned with plot.
- plot  out  1  VGA write enable for the current x/y and ROM colour.
- busy  out  1  high while a draw is in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-006 States SHALL be IDLE, DRAW, FLUSH, DONE.
REQ-007 IDLE with start=1 at a clock edge SHALL do four things: latch mode, xOrigin and yOrigin; clear count, col and row; set address to 0; go to DRAW.
REQ-008 The latched origin SHALL be treated as 0,0 when mode=0.
REQ-009 Changes to mode and origin inputs after the start edge SHALL have no effect until the next draw.
REQ-010 In DRAW, address SHALL equal count, the raster index row*W+col, W being the active width.
REQ-011 In DRAW, count SHALL increment by 1 each cycle.
REQ-012 In DRAW, col SHALL wrap to 0 at W-1 and row SHALL then increment.
REQ-013 On the edge where count=N-1 (N=W*H: 19200 screen, 1600 sprite), the block SHALL go to FLUSH.
REQ-014 In FLUSH, address SHALL hold N-1.
REQ-015 ROMs have one-cycle registered read latency. At every edge, x/y/plot SHALL register the pixel whose address was driven in the previous cycle, so the ROM q and plot are valid in the same cycle.
REQ-016 Registered x SHALL equal xOrigin+col, and registered y SHALL equal low 7 bits of (yOrigin+row), with the sum computed 8 bits wide.
REQ-017 plot SHALL be 1 for a pixel registered while the state was DRAW, unless that pixel is clipped.
REQ-018 A pixel SHALL be clipped when its 8-bit x sum >= SCREEN_W or its 8-bit y sum >= SCREEN_H; x/y still update, plot=0.
REQ-019 FLUSH SHALL last exactly one cycle (the last pixel's plot) and then go to DONE.
REQ-020 DONE SHALL last one cycle with done=1, busy=0, plot=0, then go to IDLE.
REQ-021 busy SHALL be 1 exactly in DRAW and FLUSH.
REQ-022 Per draw there SHALL be exactly N cycles with address valid, and N minus clipped-count plot pulses, contiguous with no gaps.
REQ-023 start asserted in DRAW, FLUSH or DONE SHALL be ignored (not queued).
REQ-024 start held high through DONE SHALL begin a new draw on the first IDLE edge.
REQ-025 Start to first plot SHALL be 2 edges; start to done SHALL be N+2 edges.

Reset
REQ-026 resetn=0 SHALL immediately, without a clock, force state=IDLE, count/col/row=0, address=0, x=0, y=0, plot=0, busy=0, done=0, and latched mode/origin=0.
REQ-027 Reset mid-draw SHALL abort with no further plot or done; the first start after release SHALL begin a fresh draw from address 0.

Verification
REQ-028 mode=0, start 1 cycle -> 19200 plots; first at x=0,y=0,address 0 one cycle earlier; last at x=159,y=119; done once, 19202 edges after start.
REQ-029 mode=1, origin (60,40) -> 1600 plots covering x 60..99, y 40..79; address 0..1599 sequential, each one cycle ahead of its x/y; done after 1602 edges.
REQ-030 mode=1, origin (140,100) -> x>=160 or y>=120 clipped: 20x20=400 plots; busy duration still 1601 cycles; done once.
REQ-031 start re-pulsed at DRAW cycle 500 of a sprite draw -> ignored: total plots 1600, single done, no restart.
REQ-032 resetn low for 1 cycle at sprite count 800 (mid-clock) -> plot/busy drop at once, no done; the next start yields a full 1600-plot draw from address 0.
REQ-033 start held high continuously, mode=1, origin (0,0) -> back-to-back draws: done pulse, one IDLE cycle, busy re-rises; each draw 1600 plots.
